// File: rtl/acc_mem_arbiter.sv
// acc_mem_arbiter
// Shares the single accelerator data-memory port between the FFT, FIR and IIR
// engines. One engine at a time owns the port. Ownership is revoked when the
// engine releases the port, or when its burst reaches MAX_BURST beats.
//
// Build option: define ARB_FIXED_PRIO_EN for fixed priority FFT > FIR > IIR.
// Without it the arbiter is round-robin, starting from FFT after reset.
//
// Handshake (applies to every engine):
//   - The engine raises <eng>_req and holds it at a level until it is granted or
//     until it withdraws the request.
//   - <eng>_grant is registered and one-hot. While it is high, the engine may
//     drive memory beats, and it flags each beat on mem_beat.
//   - The engine releases the port with a one-cycle <eng>_done pulse, or by
//     dropping <eng>_req. The grant falls on the next rising edge.
//   - A burst that reaches MAX_BURST beats is revoked, and preempt pulses for
//     one cycle.
//   - Between owners the port rests for two cycles (TURN, then IDLE), with
//     mem_sel = 00.
// dbg_state exposes the FSM: 0 = IDLE, 1 = BUSY, 2 = TURN.
module acc_mem_arbiter #(
  parameter int MAX_BURST = 64,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fft_req,
  input  logic             fir_req,
  input  logic             iir_req,
  input  logic             fft_done,
  input  logic             fir_done,
  input  logic             iir_done,
  input  logic             mem_beat,
  output logic             fft_grant,
  output logic             fir_grant,
  output logic             iir_grant,
  output logic [1:0]       mem_sel,
  output logic             preempt,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TURN = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);

  // Engine index: 0 = FFT, 1 = FIR, 2 = IIR. mem_sel code = index + 1.
  logic [2:0]       req_vec;
  logic [2:0]       done_vec;

  state_e           state_q,   state_d;
  logic [2:0]       grant_q,   grant_d;
  logic [1:0]       mem_sel_q, mem_sel_d;
  logic             preempt_q, preempt_d;
  logic [CNT_W-1:0] beat_q,    beat_d;

  logic [1:0]       win_idx;
  logic [CNT_W-1:0] beat_nxt;
  logic             own_done;
  logic             own_req;
  logic             release_ev;
  logic             at_max;

  assign req_vec  = {iir_req, fir_req, fft_req};
  assign done_vec = {iir_done, fir_done, fft_done};

`ifndef ARB_FIXED_PRIO_EN
  // Round-robin pointer: the engine searched first in the next arbitration.
  logic [1:0] rr_q, rr_d;
  logic [1:0] cand0, cand1, cand2;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction
`endif

  // Winner selection. The lowest-ranked candidate is written first, so the
  // highest-ranked requester overrides it.
  always_comb begin
    win_idx = 2'd0;
`ifdef ARB_FIXED_PRIO_EN
    if (req_vec[2]) win_idx = 2'd2;
    if (req_vec[1]) win_idx = 2'd1;
    if (req_vec[0]) win_idx = 2'd0;
`else
    cand0 = rr_q;
    cand1 = rr_next(cand0);
    cand2 = rr_next(cand1);
    if (req_vec[cand2]) win_idx = cand2;
    if (req_vec[cand1]) win_idx = cand1;
    if (req_vec[cand0]) win_idx = cand0;
`endif
  end

  // Burst bookkeeping for the current owner. Only the owner's done and req
  // are looked at; the other engines are masked out by the grant.
  always_comb begin
    beat_nxt   = beat_q;
    if (mem_beat && (beat_q != MAX_C)) beat_nxt = beat_q + 1'b1;
    own_done   = |(done_vec & grant_q);
    own_req    = |(req_vec & grant_q);
    release_ev = own_done || !own_req;
    at_max     = (beat_nxt == MAX_C);
  end

  // Next-state and registered-output logic for the IDLE/BUSY/TURN sequence.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    mem_sel_d = mem_sel_q;
    preempt_d = 1'b0;
    beat_d    = beat_q;
`ifndef ARB_FIXED_PRIO_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          state_d   = ST_BUSY;
          grant_d   = 3'b001 << win_idx;
          mem_sel_d = win_idx + 2'd1;
          beat_d    = '0;
`ifndef ARB_FIXED_PRIO_EN
          rr_d      = rr_next(win_idx);
`endif
        end
      end
      ST_BUSY: begin
        // A beat in the releasing cycle is still counted.
        beat_d = beat_nxt;
        if (release_ev || at_max) begin
          state_d   = ST_TURN;
          grant_d   = '0;
          mem_sel_d = 2'd0;
          // A release that coincides with the ceiling is a normal release.
          preempt_d = !release_ev;
        end
      end
      ST_TURN: begin
        state_d   = ST_IDLE;
        grant_d   = '0;
        mem_sel_d = 2'd0;
      end
      default: begin
        state_d   = ST_IDLE;
        grant_d   = '0;
        mem_sel_d = 2'd0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      mem_sel_q <= 2'd0;
      preempt_q <= 1'b0;
      beat_q    <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_q      <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      mem_sel_q <= mem_sel_d;
      preempt_q <= preempt_d;
      beat_q    <= beat_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign fft_grant = grant_q[0];
  assign fir_grant = grant_q[1];
  assign iir_grant = grant_q[2];
  assign mem_sel   = mem_sel_q;
  assign preempt   = preempt_q;
  assign beat_cnt  = beat_q;
  assign dbg_state = state_q;

endmodule

// File: doc/acc_mem_arbiter.md
# acc_mem_arbiter

Shares the single accelerator data-memory port between the FFT, FIR and IIR engines sequenced by the PLA controller. Each engine raises a request, receives an exclusive grant, and drives memory beats until it signals done. The arbiter drives the memory-port mux select and forcibly preempts any engine whose burst reaches a configurable ceiling. Arbitration is round-robin by default and can be compiled to fixed priority.

## Interface
Parameters:
- MAX_BURST, 64, beats allowed per grant before forced preemption (1..2^CNT_W-1)
- CNT_W, 7, width of beat counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- fft_req / fir_req / iir_req  in  1 each  level request, held until granted or withdrawn
- fft_done / fir_done / iir_done  in  1 each  one-cycle release pulse from the engine
- mem_beat  in  1  granted engine performed a memory access this cycle
- fft_grant / fir_grant / iir_grant  out  1 each  registered one-hot grant
- mem_sel  out  2  port mux select: 00 none, 01 FFT, 10 FIR, 11 IIR (PLA instruction encoding)
- preempt  out  1  one-cycle pulse when a grant is revoked at MAX_BURST
- beat_cnt  out  CNT_W  beats taken by current or most recent grant

## Operation
- States: IDLE, BUSY, TURN. Reset state: IDLE, all grants 0, mem_sel 00, preempt 0, beat_cnt 0, RR pointer = FFT.
- IDLE: if any req is high, choose a winner by policy. Next cycle: BUSY, winner's grant = 1, mem_sel = its code, beat_cnt = 0. With no request, stay in IDLE.
- Round-robin: search order starts at the engine after the last winner (FFT->FIR->IIR->FFT). The pointer updates on every grant.
- BUSY: mem_beat increments beat_cnt, saturating at MAX_BURST. Exit to TURN on the first of these events:
  - granted engine's done = 1
  - granted engine's req = 0
  - beat_cnt reaches MAX_BURST, causing preemption
- done or req changes from non-granted engines are ignored in BUSY.
- done and mem_beat in the same cycle: the beat is counted, then the grant is released.
- done in the same cycle as the MAX_BURST beat: treated as a normal release, preempt stays 0.
- TURN: lasts exactly one cycle. All grants 0, mem_sel 00. preempt = 1 only if the exit was due to MAX_BURST. Then IDLE.
- A preempted engine that still holds req re-competes. Under round-robin it is lowest priority.
- mem_beat outside BUSY is ignored. beat_cnt holds its final value through TURN and IDLE until the next grant.

## Timing
- Request to grant: 1 cycle (req sampled in IDLE at edge k, grant high after edge k+1).
- Release to grant drop: grant falls on the edge after done/req-low/final beat.
- Gap between consecutive grants: 2 idle cycles (TURN, IDLE), so mem_sel is 00 for at least 2 cycles between owners.
- A single requester holding req continuously with MAX_BURST=64 and mem_beat every cycle: 64 granted cycles, then 2 dead cycles, repeating.
- Reset asserted mid-BUSY: grants, mem_sel, preempt and beat_cnt go to 0 asynchronously. After release, the first rising edge starts in IDLE.

## Configuration
- ARB_FIXED_PRIO_EN defined: fixed priority FFT > FIR > IIR. The RR pointer is not implemented, and a preempted engine regains the port if it is the highest-priority requester.
- Not defined: round-robin as described in Operation.

## Test plan
- Reset, then fft_req=1 with 10 mem_beats and fft_done -> fft_grant high 1 cycle after req, beat_cnt=10, mem_sel 01 then 00, preempt 0.
- All three req held from IDLE after reset, each done after 3 beats -> grant order FFT, FIR, IIR, FFT with 2-cycle gaps (fixed-prio build: FFT repeatedly).
- fir_req only, mem_beat every cycle, MAX_BURST=64 -> preempt pulse after 64th beat, beat_cnt=64, FIR regranted 2 cycles later.
- fir granted, fft_done and iir_done pulsed -> no effect; fir_done coinciding with 64th beat -> release, preempt stays 0.
- reset low mid-BUSY (beat_cnt=5) -> all outputs 0 immediately, IIR granted first after release when only iir_req high.
- Granted engine drops req without done -> TURN, grant and mem_sel 00 on next edge, no preempt.
